rx_uart: RTL

- Serial UART receiver; the receive-side counterpart of the team's UART transmitter.
- Accepts the 8N1 line from the board pin and recovers bytes, LSB first.
- Presents each byte on a valid/ack holding register, with framing-error and overrun flags.
- Sits between the board UART pin and the consumer logic (echo, command parser).

---
 rtl/rx_uart_if.sv | 32 +++
 rtl/rx_uart.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rx_uart_if.sv
// ---------------------------------------------------------------------------
// rx_uart_if : consumer-side bus of the UART receiver.
//   i_ack       consumer has taken o_data
//   o_data      last received byte (BW-1 bits)
//   o_valid     o_data holds an unacknowledged byte
//   o_frame_err one-cycle pulse on a low stop bit
//   o_overrun   sticky: a byte completed while o_valid was still set
//   o_busy      receiver is inside a frame
//   out_bit_rx  bit index: 0 start, 1..BW-1 data, BW stop, 15 idle
// Modports: master = receiver (drives the byte side), slave = consumer.
// ---------------------------------------------------------------------------
interface rx_uart_if #(
   parameter int BW = 9
);
   logic          i_ack;
   logic [BW-2:0] o_data;
   logic          o_valid;
   logic          o_frame_err;
   logic          o_overrun;
   logic          o_busy;
   logic [3:0]    out_bit_rx;

   modport master (
      input  i_ack,
      output o_data, o_valid, o_frame_err, o_overrun, o_busy, out_bit_rx
   );

   modport slave (
      output i_ack,
      input  o_data, o_valid, o_frame_err, o_overrun, o_busy, out_bit_rx
   );
endinterface

// File: rtl/rx_uart.sv
// ---------------------------------------------------------------------------
// rx_uart : 8N1 serial receiver, LSB first, valid/ack holding register.
// Ports:
//   clk          system clock, rising edge
//   i_reset      synchronous active-high reset
//   uart_txd_in  asynchronous serial line from the pin, idle high
//   bus          rx_uart_if.master (i_ack in; o_data, o_valid, o_frame_err,
//                o_overrun, o_busy, out_bit_rx out)
// Build option:
//   RX_UART_MAJORITY_EN  when defined, each sample point is the majority of
//                        rx_s taken at timer values 2, 1 and 0; otherwise a
//                        single sample at timer 0. Timing is identical.
// ---------------------------------------------------------------------------
module rx_uart #(
   parameter int BW              = 9,
   parameter int TIMER_BITS      = 32,
   parameter int CLOCKS_PER_BAUD = 868
) (
   input  logic      clk,
   input  logic      i_reset,
   input  logic      uart_txd_in,
   rx_uart_if.master bus
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [TIMER_BITS-1:0] HALF_LOAD = TIMER_BITS'((CLOCKS_PER_BAUD >> 1) - 1);
   localparam logic [TIMER_BITS-1:0] FULL_LOAD = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
   localparam logic [3:0]            LAST_DATA = 4'(BW - 1);
   localparam logic [3:0]            STOP_IDX  = 4'(BW);
   localparam logic [3:0]            IDLE_IDX  = 4'hF;

   state_t                state_q;
   logic                  sync1_q, sync2_q;
   logic [1:0]            fill_q;
   logic                  prev_q;
   logic [TIMER_BITS-1:0] timer_q;
   logic [BW-2:0]         shift_q, data_q;
   logic                  valid_q, ovr_q, ferr_q, busy_q;
   logic [3:0]            bit_q;

   logic rx_s;
   logic tick_d;
   logic edge_d;
   logic samp_d;

   assign rx_s   = sync2_q;
   assign tick_d = (timer_q == '0);
   // prev_q only ever holds a genuinely observed line level, so a line that
   // is low straight out of reset (or after a break) must go high first.
   assign edge_d = prev_q & ~rx_s;

`ifdef RX_UART_MAJORITY_EN
   logic s2_q, s1_q;

   always_ff @(posedge clk) begin
      if (i_reset) begin
         s2_q <= 1'b1;
         s1_q <= 1'b1;
      end else begin
         if (timer_q == TIMER_BITS'(2)) s2_q <= rx_s;
         if (timer_q == TIMER_BITS'(1)) s1_q <= rx_s;
      end
   end

   // Reload values are always >= 3, so the 2/1 samples precede every tick.
   assign samp_d = (s2_q & s1_q) | (s2_q & rx_s) | (s1_q & rx_s);
`else
   assign samp_d = rx_s;
`endif

   always_ff @(posedge clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         fill_q  <= 2'b00;
         prev_q  <= 1'b0;
         timer_q <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
         bit_q   <= IDLE_IDX;
      end else begin
         sync1_q <= uart_txd_in;
         sync2_q <= sync1_q;
         // fill_q marks when sync2_q has left its reset value and reflects the pin.
         fill_q  <= {fill_q[0], 1'b1};
         prev_q  <= fill_q[1] ? rx_s : 1'b0;
         ferr_q  <= 1'b0;

         if (bus.i_ack && valid_q) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (edge_d) begin
                  timer_q <= HALF_LOAD;
                  state_q <= START;
                  bit_q   <= 4'd0;
                  busy_q  <= 1'b1;
               end
            end
            START: begin
               if (!tick_d) begin
                  timer_q <= timer_q - 1'b1;
               end else if (samp_d) begin
                  // false start: line already back high at mid start bit
                  state_q <= IDLE;
                  bit_q   <= IDLE_IDX;
                  busy_q  <= 1'b0;
               end else begin
                  timer_q <= FULL_LOAD;
                  state_q <= DATA;
                  bit_q   <= 4'd1;
               end
            end
            DATA: begin
               if (!tick_d) begin
                  timer_q <= timer_q - 1'b1;
               end else begin
                  // LSB arrives first and ends up in bit 0 after the last shift
                  shift_q <= {samp_d, shift_q[BW-2:1]};
                  timer_q <= FULL_LOAD;
                  if (bit_q == LAST_DATA) begin
                     state_q <= STOP;
                     bit_q   <= STOP_IDX;
                  end else begin
                     bit_q <= bit_q + 4'd1;
                  end
               end
            end
            STOP: begin
               if (!tick_d) begin
                  timer_q <= timer_q - 1'b1;
               end else begin
                  if (samp_d) begin
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
                     // a same-cycle ack consumes the old byte: no overrun
                     if (valid_q && !bus.i_ack) ovr_q <= 1'b1;
                  end else begin
                     ferr_q <= 1'b1;
                  end
                  state_q <= IDLE;
                  bit_q   <= IDLE_IDX;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               bit_q   <= IDLE_IDX;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_data      = data_q;
   assign bus.o_valid     = valid_q;
   assign bus.o_frame_err = ferr_q;
   assign bus.o_overrun   = ovr_q;
   assign bus.o_busy      = busy_q;
   assign bus.out_bit_rx  = bit_q;

endmodule
